// File: rtl/dma_xfer_sched_if.sv
// Bundle of the command, DMA-engine and status signals around dma_xfer_sched.
// master: the side that issues commands and returns DMA done pulses.
// slave:  the scheduler itself.
interface dma_xfer_sched_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int BITS_TRANS   = 18,
    parameter int CMDQ_DEPTH   = 4
);
    localparam int QL_W = $clog2(CMDQ_DEPTH) + 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [AXI_WIDTH_AD-1:0] cmd_addr;
    logic [BITS_TRANS-1:0]   cmd_len;
    logic                    dma_rd_start;
    logic                    dma_wr_start;
    logic [BITS_TRANS-1:0]   num_trans;
    logic [AXI_WIDTH_AD-1:0] start_addr;
    logic                    dma_rd_done;
    logic                    dma_wr_done;
    logic                    busy;
    logic                    cmd_done;
    logic                    cmd_err;
    logic [QL_W-1:0]         queue_level;

    modport master (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len, dma_rd_done, dma_wr_done,
        input  cmd_ready, dma_rd_start, dma_wr_start, num_trans, start_addr,
               busy, cmd_done, cmd_err, queue_level
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len, dma_rd_done, dma_wr_done,
        output cmd_ready, dma_rd_start, dma_wr_start, num_trans, start_addr,
               busy, cmd_done, cmd_err, queue_level
    );
endinterface

// File: rtl/dma_xfer_sched.sv
// DMA command scheduler: queues {dir, addr, len} commands and splits each into
// bursts of at most MAX_CHUNK words that never cross a 4 KB page, driving the
// read or write DMA engine one job at a time with a per-job done watchdog.
module dma_xfer_sched #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int BITS_TRANS   = 18,
    parameter int MAX_CHUNK    = 256,
    parameter int CMDQ_DEPTH   = 4,
    parameter int TIMEOUT      = 65535
) (
    input logic             clk,
    input logic             rst,
    dma_xfer_sched_if.slave bus
);
    localparam int  PTR_W   = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
    localparam int  QL_W    = $clog2(CMDQ_DEPTH) + 1;
    localparam int  ENTRY_W = 1 + AXI_WIDTH_AD + BITS_TRANS;
    localparam bit  WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    // Command queue storage and pointers
    logic [ENTRY_W-1:0]      q_mem [CMDQ_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [QL_W-1:0]         count_reg;
    logic                    q_full;
    logic                    q_empty;
    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      q_head;
    logic                    head_dir;
    logic [AXI_WIDTH_AD-1:0] head_addr;
    logic [BITS_TRANS-1:0]   head_len;
    logic [AXI_WIDTH_AD-1:0] addr_aligned;

    // Working registers of the active command
    state_t                  state_reg;
    logic                    dir_reg;
    logic [AXI_WIDTH_AD-1:0] addr_reg;
    logic [BITS_TRANS-1:0]   rem_reg;
    logic [BITS_TRANS-1:0]   chunk_reg;
    logic [31:0]             wdog_reg;

    // Registered outputs
    logic                    rd_start_reg;
    logic                    wr_start_reg;
    logic [BITS_TRANS-1:0]   num_trans_reg;
    logic [AXI_WIDTH_AD-1:0] start_addr_reg;
    logic                    cmd_done_reg;
    logic                    cmd_err_reg;

    // Chunk sizing
    logic [12:0]             bnd_bytes;
    logic [BITS_TRANS-1:0]   bnd_words;
    logic [BITS_TRANS-1:0]   chunk_calc;
    logic                    match_done;

    assign q_full       = (count_reg == QL_W'(CMDQ_DEPTH));
    assign q_empty      = (count_reg == '0);
    assign push         = bus.cmd_valid & bus.cmd_ready;
    assign pop          = (state_reg == S_IDLE) & ~q_empty;
    assign addr_aligned = bus.cmd_addr & ~(AXI_WIDTH_AD'(3));

    assign q_head    = q_mem[rd_ptr_reg];
    assign head_dir  = q_head[ENTRY_W-1];
    assign head_addr = q_head[BITS_TRANS +: AXI_WIDTH_AD];
    assign head_len  = q_head[BITS_TRANS-1:0];

    // A done from the engine that is not running the current job is ignored.
    assign match_done = dir_reg ? bus.dma_wr_done : bus.dma_rd_done;

    // Queue entry write; word-aligned address is stored so the low bits never reach the engines
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= {bus.cmd_dir, addr_aligned, bus.cmd_len};
        end
    end

    // Queue pointers and occupancy; push and pop in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + QL_W'(1);
                2'b01:   count_reg <= count_reg - QL_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Burst length = min(remaining, MAX_CHUNK, words left in the current 4 KB page)
    always_comb begin
        bnd_bytes  = 13'd4096 - {1'b0, addr_reg[11:0]};
        bnd_words  = BITS_TRANS'(bnd_bytes >> 2);
        chunk_calc = rem_reg;
        if (chunk_calc > BITS_TRANS'(MAX_CHUNK)) begin
            chunk_calc = BITS_TRANS'(MAX_CHUNK);
        end
        if (chunk_calc > bnd_words) begin
            chunk_calc = bnd_words;
        end
    end

    // Scheduler FSM; pulse outputs default low and are set on the edge entering their state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            dir_reg        <= 1'b0;
            addr_reg       <= '0;
            rem_reg        <= '0;
            chunk_reg      <= '0;
            wdog_reg       <= '0;
            rd_start_reg   <= 1'b0;
            wr_start_reg   <= 1'b0;
            num_trans_reg  <= '0;
            start_addr_reg <= '0;
            cmd_done_reg   <= 1'b0;
            cmd_err_reg    <= 1'b0;
        end else begin
            rd_start_reg <= 1'b0;
            wr_start_reg <= 1'b0;
            cmd_done_reg <= 1'b0;
            cmd_err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!q_empty) begin
                        dir_reg  <= head_dir;
                        addr_reg <= head_addr;
                        rem_reg  <= head_len;
                        if (head_len == '0) begin
                            cmd_done_reg <= 1'b1;
                            state_reg    <= S_DONE;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // Job parameters are loaded together with the start pulse so
                    // the engine sees them valid in the START cycle.
                    chunk_reg      <= chunk_calc;
                    num_trans_reg  <= chunk_calc;
                    start_addr_reg <= addr_reg;
                    rd_start_reg   <= ~dir_reg;
                    wr_start_reg   <= dir_reg;
                    state_reg      <= S_START;
                end
                S_START: begin
                    wdog_reg  <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (match_done) begin
                        addr_reg <= addr_reg + AXI_WIDTH_AD'({chunk_reg, 2'b00});
                        rem_reg  <= rem_reg - chunk_reg;
                        if (rem_reg == chunk_reg) begin
                            cmd_done_reg <= 1'b1;
                            state_reg    <= S_DONE;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end else begin
                        wdog_reg <= wdog_reg + 32'd1;
                        if (WDOG_EN && ((wdog_reg + 32'd1) == 32'(TIMEOUT))) begin
                            cmd_err_reg <= 1'b1;
                            state_reg   <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                S_ERR: begin
                    // Remaining chunks are dropped; queued commands stay put.
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = ~q_full & ~rst;
    assign bus.dma_rd_start = rd_start_reg;
    assign bus.dma_wr_start = wr_start_reg;
    assign bus.num_trans    = num_trans_reg;
    assign bus.start_addr   = start_addr_reg;
    assign bus.busy         = (state_reg != S_IDLE) | ~q_empty;
    assign bus.cmd_done     = cmd_done_reg;
    assign bus.cmd_err      = cmd_err_reg;
    assign bus.queue_level  = count_reg;
endmodule

// File: tb/tb_dma_xfer_sched.sv
// Directed bench for dma_xfer_sched: chunking, page splitting, zero length,
// queue back-pressure, reset mid-job and the done watchdog.
`timescale 1ns/1ps
module tb_dma_xfer_sched;
    logic clk;
    logic rst;

    dma_xfer_sched_if #(.AXI_WIDTH_AD(32), .BITS_TRANS(18), .CMDQ_DEPTH(4)) bus ();

    dma_xfer_sched #(
        .AXI_WIDTH_AD(32),
        .BITS_TRANS  (18),
        .MAX_CHUNK   (256),
        .CMDQ_DEPTH  (4),
        .TIMEOUT     (100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_rd_start = 0;
    int n_wr_start = 0;
    int n_done = 0;
    int n_err = 0;
    int n_multi = 0;
    int exp_n [$];
    int exp_a [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.dma_rd_start) n_rd_start++;
        if (bus.dma_wr_start) n_wr_start++;
        if (bus.cmd_done) n_done++;
        if (bus.cmd_err) n_err++;
        if ((int'(bus.dma_rd_start) + int'(bus.dma_wr_start) + int'(bus.cmd_done) + int'(bus.cmd_err)) > 1)
            n_multi++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns in the cycle after it was accepted
    task automatic send(input logic dir, input logic [31:0] addr, input logic [17:0] len);
        int n = 0;
        bus.cmd_dir   = dir;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check_val("cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        $display("cmd dir=%0d addr=0x%0h len=%0d accepted", dir, addr, len);
    endtask

    // Called in the first start cycle; walks the expected chunk list, returning
    // each done wait_cyc cycles after its start. Ends in the cmd_done cycle.
    task automatic do_chunks(input logic dir, input int wait_cyc);
        for (int i = 0; i < exp_n.size(); i++) begin
            check_val("rd_start", 64'(bus.dma_rd_start), 64'(!dir));
            check_val("wr_start", 64'(bus.dma_wr_start), 64'(dir));
            check_val("num_trans", 64'(bus.num_trans), 64'(exp_n[i]));
            check_val("start_addr", 64'(bus.start_addr), 64'(exp_a[i]));
            $display("chunk dir=%0d num_trans=%0d start_addr=0x%0h", dir, bus.num_trans, bus.start_addr);
            repeat (wait_cyc) tick();
            check_val("num_trans_hold", 64'(bus.num_trans), 64'(exp_n[i]));
            if (dir) bus.dma_wr_done = 1'b1;
            else     bus.dma_rd_done = 1'b1;
            tick();
            bus.dma_wr_done = 1'b0;
            bus.dma_rd_done = 1'b0;
            if (i == exp_n.size() - 1) begin
                check_val("cmd_done", 64'(bus.cmd_done), 64'd1);
            end else begin
                check_val("cmd_done_early", 64'(bus.cmd_done), 64'd0);
                tick();
            end
        end
    endtask

    task automatic settle_idle();
        repeat (3) tick();
        check_val("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int r0;
        int w0;
        int d0;
        int e0;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_dir     = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.dma_rd_done = 1'b0;
        bus.dma_wr_done = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_ready", 64'(bus.cmd_ready), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_level", 64'(bus.queue_level), 64'd0);
        check_val("rst_num", 64'(bus.num_trans), 64'd0);
        check_val("rst_addr", 64'(bus.start_addr), 64'd0);
        rst = 1'b0;
        tick();
        check_val("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

        // Write, addr 0, len 8; done 20 cycles after start
        r0 = n_rd_start;
        send(1'b1, 32'h0, 18'd8);
        tick(); tick();
        exp_n = '{8};
        exp_a = '{0};
        do_chunks(1'b1, 20);
        settle_idle();
        check_val("wr_no_rd_start", 64'(n_rd_start - r0), 64'd0);

        // Read, addr 0, len 600: 256 / 256 / 88
        d0 = n_done;
        send(1'b0, 32'h0, 18'd600);
        tick(); tick();
        exp_n = '{256, 256, 88};
        exp_a = '{32'h000, 32'h400, 32'h800};
        do_chunks(1'b0, 5);
        settle_idle();
        check_val("one_done_600", 64'(n_done - d0), 64'd1);

        // Page crossing: 0xFF0 len 10 -> (4, 0xFF0), (6, 0x1000)
        send(1'b0, 32'hFF0, 18'd10);
        tick(); tick();
        exp_n = '{4, 6};
        exp_a = '{32'hFF0, 32'h1000};
        do_chunks(1'b0, 3);
        settle_idle();

        // Unaligned address is forced to a word boundary
        send(1'b0, 32'h003, 18'd1);
        tick(); tick();
        exp_n = '{1};
        exp_a = '{0};
        do_chunks(1'b0, 2);
        settle_idle();

        // Zero length then write len 4
        r0 = n_rd_start;
        w0 = n_wr_start;
        e0 = n_err;
        send(1'b0, 32'h40, 18'd0);
        send(1'b1, 32'h80, 18'd4);
        check_val("zero_len_done", 64'(bus.cmd_done), 64'd1);
        check_val("zero_len_no_start", 64'(n_rd_start + n_wr_start - r0 - w0), 64'd0);
        tick();
        check_val("zero_len_done_pulse", 64'(bus.cmd_done), 64'd0);
        tick(); tick();
        exp_n = '{4};
        exp_a = '{32'h80};
        do_chunks(1'b1, 4);
        settle_idle();
        check_val("zero_len_no_err", 64'(n_err - e0), 64'd0);

        // Watchdog: read len 512 with done withheld, write queued behind it
        r0 = n_rd_start;
        d0 = n_done;
        send(1'b0, 32'h2000, 18'd512);
        send(1'b1, 32'h100, 18'd2);
        tick();
        check_val("wd_rd_start", 64'(bus.dma_rd_start), 64'd1);
        check_val("wd_num", 64'(bus.num_trans), 64'd256);
        for (int i = 1; i <= 100; i++) begin
            tick();
            bus.dma_wr_done = (i == 7);
        end
        bus.dma_wr_done = 1'b0;
        check_val("wd_err_early", 64'(bus.cmd_err), 64'd0);
        tick();
        check_val("wd_err", 64'(bus.cmd_err), 64'd1);
        check_val("wd_one_chunk", 64'(n_rd_start - r0), 64'd1);
        check_val("wd_no_done", 64'(n_done - d0), 64'd0);
        $display("cmd dir=0 addr=0x2000 aborted by watchdog");
        repeat (3) tick();
        exp_n = '{2};
        exp_a = '{32'h100};
        do_chunks(1'b1, 3);
        settle_idle();

        // Queue full with done withheld, then reset mid-WAIT
        for (int i = 0; i < 5; i++) begin
            bus.cmd_dir   = 1'b0;
            bus.cmd_addr  = 32'(i * 32'h100);
            bus.cmd_len   = 18'd4;
            bus.cmd_valid = 1'b1;
            check_val("fill_ready", 64'(bus.cmd_ready), 64'd1);
            tick();
            $display("cmd dir=0 addr=0x%0h len=4 accepted", i * 32'h100);
        end
        bus.cmd_addr = 32'h500;
        check_val("full_level", 64'(bus.queue_level), 64'd4);
        check_val("full_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        bus.dma_rd_done = 1'b1;
        tick();
        bus.dma_rd_done = 1'b0;
        check_val("full_first_done", 64'(bus.cmd_done), 64'd1);
        tick();
        check_val("full_ready_pop", 64'(bus.cmd_ready), 64'd0);
        tick();
        check_val("freed_ready", 64'(bus.cmd_ready), 64'd1);
        check_val("freed_level", 64'(bus.queue_level), 64'd3);
        tick();
        bus.cmd_valid = 1'b0;
        check_val("refill_level", 64'(bus.queue_level), 64'd4);
        $display("cmd dir=0 addr=0x500 len=4 accepted");
        tick(); tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_rd_start", 64'(bus.dma_rd_start), 64'd0);
        check_val("mid_rst_wr_start", 64'(bus.dma_wr_start), 64'd0);
        check_val("mid_rst_num", 64'(bus.num_trans), 64'd0);
        check_val("mid_rst_addr", 64'(bus.start_addr), 64'd0);
        check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_val("mid_rst_done", 64'(bus.cmd_done), 64'd0);
        check_val("mid_rst_err", 64'(bus.cmd_err), 64'd0);
        check_val("mid_rst_level", 64'(bus.queue_level), 64'd0);
        check_val("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        r0 = n_rd_start + n_wr_start;
        repeat (6) tick();
        check_val("post_rst_no_start", 64'(n_rd_start + n_wr_start - r0), 64'd0);
        check_val("post_rst_busy", 64'(bus.busy), 64'd0);
        check_val("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

        check_val("exclusive_pulses", 64'(n_multi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
